execute_stage: RTL and testbench

- Pipeline execute stage that sits directly downstream of the ID-stage ALU control decode.
- Takes the decoded 4-bit ALU control, operands and forwarding selects, and computes the ALU result.
- Holds the result in an EX/MEM output register with valid/ready handshake, stall back-pressure and flush.
- One-cycle latency; result feeds the memory stage and the forwarding network.

---
 rtl/pipeline_pkg.sv | 35 +++
 rtl/alu_core.sv | 41 ++++
 rtl/execute_stage.sv | 104 ++++++++++
 tb/tb_execute_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the execute stage: ALU op codes, forwarding selects and the EX/MEM record.
package pipeline_pkg;

    localparam int unsigned PKG_XLEN  = 32;
    localparam int unsigned PKG_TAG_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'b0000,
        ALU_SLL     = 4'b0001,
        ALU_SLT     = 4'b0010,
        ALU_SLTU    = 4'b0011,
        ALU_XOR     = 4'b0100,
        ALU_SRL     = 4'b0101,
        ALU_OR      = 4'b0110,
        ALU_AND     = 4'b0111,
        ALU_SUB     = 4'b1000,
        ALU_LUI     = 4'b1001,
        ALU_SRA     = 4'b1101,
        ALU_ILLEGAL = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic [PKG_XLEN-1:0]  result;
        logic [PKG_TAG_W-1:0] rd;
        logic [PKG_XLEN-1:0]  store_data;
        logic                 illegal;
    } ex_mem_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: decodes the 4-bit control and produces the result plus an illegal flag.
module alu_core
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN = PKG_XLEN
) (
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    logic [4:0] shamt;
    logic       lt_signed;
    logic       lt_unsigned;

    assign shamt       = b[4:0];
    assign lt_signed   = $signed(a) < $signed(b);
    assign lt_unsigned = a < b;

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (alu_op_e'(alu_control))
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = XLEN'($signed(a) >>> shamt);
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_unsigned};
            ALU_XOR:  result = a ^ b;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_LUI:  result = b;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, and the EX/MEM output register with
// valid/ready handshake, stall and flush.
module execute_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN  = PKG_XLEN,
    parameter int unsigned TAG_W = PKG_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  imm,
    input  logic             use_imm,
    input  logic [TAG_W-1:0] rd,
    input  logic [1:0]       fwd_a_sel,
    input  logic [1:0]       fwd_b_sel,
    input  logic [XLEN-1:0]  mem_fwd,
    input  logic [XLEN-1:0]  wb_fwd,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_rd,
    output logic [XLEN-1:0]  out_store_data,
    output logic             out_illegal
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_illegal;
    logic            accept;
    logic            valid_q;
    ex_mem_t         ex_d;
    ex_mem_t         ex_q;

    // Reserved select 2'b11 falls back to the register file.
    always_comb begin
        case (fwd_sel_e'(fwd_a_sel))
            FWD_MEM: op_a = mem_fwd;
            FWD_WB:  op_a = wb_fwd;
            default: op_a = rs1_data;
        endcase
    end

    always_comb begin
        case (fwd_sel_e'(fwd_b_sel))
            FWD_MEM: fwd_b = mem_fwd;
            FWD_WB:  fwd_b = wb_fwd;
            default: fwd_b = rs2_data;
        endcase
    end

    assign op_b = use_imm ? imm : fwd_b;

    alu_core #(
        .XLEN(XLEN)
    ) u_alu_core (
        .alu_control(alu_control),
        .a          (op_a),
        .b          (op_b),
        .result     (alu_result),
        .illegal    (alu_illegal)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        ex_d            = ex_q;
        ex_d.result     = alu_result;
        ex_d.rd         = rd;
        ex_d.store_data = fwd_b;
        ex_d.illegal    = alu_illegal;
    end

    // Flush wins over accept; data fields may keep stale values, only valid and illegal clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ex_q    <= '0;
        end else if (flush) begin
            valid_q      <= 1'b0;
            ex_q.illegal <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            ex_q    <= ex_d;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid      = valid_q;
    assign out_result     = ex_q.result;
    assign out_rd         = ex_q.rd;
    assign out_store_data = ex_q.store_data;
    assign out_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: vector table plus scoreboard, and
// hand-written stall, flush and reset-in-flight sequences.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        use_imm;
    logic [4:0]  rd;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic [31:0] mem_fwd;
    logic [31:0] wb_fwd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic [31:0] out_store_data;
    logic        out_illegal;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_control   (alu_control),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .imm           (imm),
        .use_imm       (use_imm),
        .rd            (rd),
        .fwd_a_sel     (fwd_a_sel),
        .fwd_b_sel     (fwd_b_sel),
        .mem_fwd       (mem_fwd),
        .wb_fwd        (wb_fwd),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_rd        (out_rd),
        .out_store_data(out_store_data),
        .out_illegal   (out_illegal)
    );

    typedef struct {
        logic [3:0]  alu;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        use_imm;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] memf;
        logic [31:0] wbf;
        logic [31:0] exp_res;
        logic [31:0] exp_store;
        logic        exp_ill;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic [31:0] store;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    // Scoreboard: a transfer completes at the next posedge whenever valid&ready at negedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_output: got rd=%0d result=0x%08h, expected none",
                         out_rd, out_result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_result", out_result, e.res);
                check("out_rd", 32'(out_rd), 32'(e.rd));
                check("out_store_data", out_store_data, e.store);
                check("out_illegal", 32'(out_illegal), 32'(e.ill));
            end
        end
    end

    task automatic drive(input vec_t v, input logic [4:0] tag);
        in_valid    = 1'b1;
        alu_control = v.alu;
        rs1_data    = v.rs1;
        rs2_data    = v.rs2;
        imm         = v.imm;
        use_imm     = v.use_imm;
        fwd_a_sel   = v.fa;
        fwd_b_sel   = v.fb;
        mem_fwd     = v.memf;
        wb_fwd      = v.wbf;
        rd          = tag;
    endtask

    function automatic exp_t to_exp(input vec_t v, input logic [4:0] tag);
        exp_t e;
        e.res   = v.exp_res;
        e.rd    = tag;
        e.store = v.exp_store;
        e.ill   = v.exp_ill;
        return e;
    endfunction

    // Drive one instruction, wait (bounded) for acceptance, push its expectation.
    task automatic send(input vec_t v, input logic [4:0] tag);
        bit done = 1'b0;
        drive(v, tag);
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                exp_q.push_back(to_exp(v, tag));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'(0));
    endtask

    vec_t vecs[16];
    vec_t va;
    vec_t vb;

    initial begin
        //         alu      rs1           rs2           imm           ui   fa     fb     memf  wbf  res           store         ill
        vecs[0]  = '{4'b0000, 32'd5,        32'd7,        32'd0,        1'b0, 2'b00, 2'b00, 32'd0,  32'd0,  32'd12,       32'd7,        1'b0};
        vecs[1]  = '{4'b1101, 32'h80000000, 32'h55,       32'd31,       1'b1, 2'b00, 2'b00, 32'd0,  32'd0,  32'hFFFFFFFF, 32'h55,       1'b0};
        vecs[2]  = '{4'b0101, 32'h80000000, 32'h55,       32'd31,       1'b1, 2'b00, 2'b00, 32'd0,  32'd0,  32'h00000001, 32'h55,       1'b0};
        vecs[3]  = '{4'b0010, 32'h80000000, 32'd1,        32'd0,        1'b0, 2'b00, 2'b00, 32'd0,  32'd0,  32'd1,        32'd1,        1'b0};
        vecs[4]  = '{4'b0011, 32'h80000000, 32'd1,        32'd0,        1'b0, 2'b00, 2'b00, 32'd0,  32'd0,  32'd0,        32'd1,        1'b0};
        vecs[5]  = '{4'b1000, 32'd999,      32'd888,      32'd0,        1'b0, 2'b01, 2'b10, 32'd100, 32'd3, 32'd97,       32'd3,        1'b0};
        vecs[6]  = '{4'b0000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 2'b00, 2'b00, 32'd0,  32'd0,  32'd0,        32'd1,        1'b0};
        vecs[7]  = '{4'b1010, 32'd5,        32'd6,        32'd0,        1'b0, 2'b00, 2'b00, 32'd0,  32'd0,  32'd0,        32'd6,        1'b1};
        vecs[8]  = '{4'b1001, 32'd5,        32'd6,        32'h12345000, 1'b1, 2'b00, 2'b00, 32'd0,  32'd0,  32'h12345000, 32'd6,        1'b0};
        vecs[9]  = '{4'b0100, 32'hF0F0,     32'h0FF0,     32'd0,        1'b0, 2'b00, 2'b00, 32'd0,  32'd0,  32'hFF00,     32'h0FF0,     1'b0};
        vecs[10] = '{4'b0110, 32'hF000,     32'h000F,     32'd0,        1'b0, 2'b00, 2'b00, 32'd0,  32'd0,  32'hF00F,     32'h000F,     1'b0};
        vecs[11] = '{4'b0111, 32'hFF00,     32'h0FF0,     32'd0,        1'b0, 2'b00, 2'b00, 32'd0,  32'd0,  32'h0F00,     32'h0FF0,     1'b0};
        vecs[12] = '{4'b0001, 32'd1,        32'd4,        32'd0,        1'b0, 2'b00, 2'b00, 32'd0,  32'd0,  32'h10,       32'd4,        1'b0};
        vecs[13] = '{4'b0000, 32'd10,       32'd20,       32'd0,        1'b0, 2'b11, 2'b11, 32'd77, 32'd88, 32'd30,       32'd20,       1'b0};
        vecs[14] = '{4'b1111, 32'd3,        32'd4,        32'd0,        1'b0, 2'b00, 2'b00, 32'd0,  32'd0,  32'd0,        32'd4,        1'b1};
        vecs[15] = '{4'b0000, 32'd1,        32'd9,        32'd2,        1'b1, 2'b00, 2'b01, 32'd50, 32'd0,  32'd3,        32'd50,       1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        alu_control = '0; rs1_data = '0; rs2_data = '0; imm = '0; use_imm = 1'b0;
        rd = '0; fwd_a_sel = '0; fwd_b_sel = '0; mem_fwd = '0; wb_fwd = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'(0));
        check("rst_out_store_data", out_store_data, 32'd0);
        check("rst_out_illegal", 32'(out_illegal), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back table, one instruction per cycle.
        for (int i = 0; i < 16; i++) send(vecs[i], 5'(i + 1));
        drain();

        // Stall: A held for 3 cycles while B waits, then both drain in order.
        va = vecs[0];
        vb = vecs[9];
        out_ready = 1'b0;
        drive(va, 5'd20);
        @(negedge clk);
        check("stall_first_in_ready", 32'(in_ready), 32'(1));
        exp_q.push_back(to_exp(va, 5'd20));
        @(posedge clk);
        #1;
        drive(vb, 5'd21);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'(0));
            check("stall_out_valid", 32'(out_valid), 32'(1));
            check("stall_out_result", out_result, 32'd12);
            check("stall_out_rd", 32'(out_rd), 32'(20));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'(1));
        exp_q.push_back(to_exp(vb, 5'd21));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Flush: held illegal output is killed along with the incoming instruction.
        out_ready = 1'b0;
        drive(vecs[14], 5'd22);
        @(posedge clk);
        #1;
        check("pre_flush_out_valid", 32'(out_valid), 32'(1));
        check("pre_flush_out_illegal", 32'(out_illegal), 32'(1));
        drive(vecs[0], 5'd23);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'(0));
        check("flush_out_illegal", 32'(out_illegal), 32'(0));
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("flush_no_accept", 32'(out_valid), 32'(0));

        // Reset while an output is held: cleared asynchronously.
        out_ready = 1'b0;
        drive(vecs[8], 5'd24);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("pre_rst_out_valid", 32'(out_valid), 32'(1));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'(0));
        check("async_rst_out_result", out_result, 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_idle", 32'(out_valid), 32'(0));
        check("final_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
